// File: rtl/tile_pkg.sv
// tile_pkg: shared map geometry, tile index type, sweep FSM states and cell addressing
package tile_pkg;
    localparam int TILE_IDX_W = 4;
    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int TILE_LOG2  = 5;
    typedef logic [TILE_IDX_W-1:0] tile_idx_t;
    typedef enum logic {IDLE, SWEEP} sweep_state_t;
    function automatic int cell_addr(input int row, input int col, input int cols = MAP_COLS);
        return row * cols + col;
    endfunction
endpackage

// File: rtl/tile_map_ram.sv
// tile_map_ram: single-write, synchronous read-first RAM holding the tile map
module tile_map_ram #(
    parameter int DEPTH = 300,
    parameter int W     = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // read sees the value stored before any same-cycle write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/tile_map_renderer.sv
// tile_map_renderer: tile-map background renderer with runtime write, fill and reset clear
module tile_map_renderer
    import tile_pkg::*;
#(
    parameter int COLS       = tile_pkg::MAP_COLS,
    parameter int ROWS       = tile_pkg::MAP_ROWS,
    parameter int TILE_LOG2  = tile_pkg::TILE_LOG2,
    parameter int IDX_W      = tile_pkg::TILE_IDX_W,
    parameter int RESET_TILE = 1,
    parameter int PIX_W      = 12,
    parameter int CNT_W      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CNT_W-1:0]            h_cnt,
    input  logic [CNT_W-1:0]            v_cnt,
    input  logic                        active_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        wr_en,
    input  logic [$clog2(COLS)-1:0]     wr_col,
    input  logic [$clog2(ROWS)-1:0]     wr_row,
    input  logic [IDX_W-1:0]            wr_tile,
    input  logic                        fill_en,
    input  logic [IDX_W-1:0]            fill_tile,
    output logic                        busy,
    output logic [IDX_W+2*TILE_LOG2-1:0] rom_addr,
    input  logic [PIX_W-1:0]            rom_data,
    output logic [PIX_W-1:0]            pixel_out,
    output logic                        hsync_out,
    output logic                        vsync_out
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int HW = CNT_W - TILE_LOG2;

    sweep_state_t          state;
    logic [AW-1:0]         ptr;
    logic [IDX_W-1:0]      sweep_val;
    logic                  wr_ok;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [IDX_W-1:0]      wdata;
    logic [HW-1:0]         h_col;
    logic [HW-1:0]         v_row;
    logic                  in_map;
    logic [AW-1:0]         raddr;
    logic [IDX_W-1:0]      tile_q;
    logic [TILE_LOG2-1:0]  x1;
    logic [TILE_LOG2-1:0]  y1;
    logic                  v1;
    logic                  act1;
    logic                  hs1;
    logic                  vs1;
    logic                  act2;
    logic                  hs2;
    logic                  vs2;

    assign busy = (state == SWEEP);

    // sweep FSM: reset clear or fill walks every cell once, one per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SWEEP;
            sweep_val <= IDX_W'(RESET_TILE);
            ptr       <= '0;
        end else if (state == SWEEP) begin
            ptr   <= ptr + 1'b1;
            state <= (ptr == AW'(N - 1)) ? IDLE : SWEEP;
        end else if (fill_en) begin
            state     <= SWEEP;
            sweep_val <= fill_tile;
            ptr       <= '0;
        end
    end

    // write arbitration: sweep owns the port; a fill start swallows a same-cycle write
    always_comb begin
        wr_ok = wr_en && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
        we    = !rst && (busy || (wr_ok && !fill_en));
        waddr = busy ? ptr : AW'(cell_addr(int'(wr_row), int'(wr_col), COLS));
        wdata = busy ? sweep_val : wr_tile;
    end

    // read address from the tile coordinates; off-map positions read cell 0
    always_comb begin
        h_col  = h_cnt[CNT_W-1:TILE_LOG2];
        v_row  = v_cnt[CNT_W-1:TILE_LOG2];
        in_map = (int'(h_col) < COLS) && (int'(v_row) < ROWS);
        raddr  = in_map ? AW'(cell_addr(int'(v_row), int'(h_col), COLS)) : '0;
    end

    tile_map_ram #(.DEPTH(N), .W(IDX_W), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (tile_q)
    );

    assign rom_addr = v1 ? {tile_q, y1, x1} : '0;

    // stage 1: pixel offsets and control alongside the map read
    always_ff @(posedge clk) begin
        if (rst) begin
            x1   <= '0;
            y1   <= '0;
            v1   <= 1'b0;
            act1 <= 1'b0;
            hs1  <= 1'b1;
            vs1  <= 1'b1;
        end else begin
            x1   <= h_cnt[TILE_LOG2-1:0];
            y1   <= v_cnt[TILE_LOG2-1:0];
            v1   <= 1'b1;
            act1 <= active_in && in_map;
            hs1  <= hsync_in;
            vs1  <= vsync_in;
        end
    end

    // stage 2 and 3: wait out the ROM latency, then blank or pass the ROM pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            act2      <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
            pixel_out <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            act2      <= act1;
            hs2       <= hs1;
            vs2       <= vs1;
            pixel_out <= (act2 && !busy) ? rom_data : '0;
            hsync_out <= hs2;
            vsync_out <= vs2;
        end
    end
endmodule

// File: tb/tb_tile_map_renderer.sv
// tb_tile_map_renderer: directed checks of clear, write, fill, reset-abort and pipeline timing
module tb_tile_map_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic        active_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_col = '0;
    logic [3:0]  wr_row = '0;
    logic [3:0]  wr_tile = '0;
    logic        fill_en = 1'b0;
    logic [3:0]  fill_tile = '0;
    logic        busy;
    logic [13:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [11:0] pixel_out;
    logic        hsync_out;
    logic        vsync_out;
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  model [300];
    logic [11:0] px;

    tile_map_renderer dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .active_in(active_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_col(wr_col),
        .wr_row(wr_row), .wr_tile(wr_tile), .fill_en(fill_en), .fill_tile(fill_tile),
        .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data), .pixel_out(pixel_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #20 clk = ~clk;

    // ROM model: registered, colour equals the tile index
    always_ff @(posedge clk) rom_data <= {8'h0, rom_addr[13:10]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int h, input int v, output logic [11:0] p);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        active_in = 1'b1;
        repeat (3) tick;
        p = pixel_out;
    endtask

    task automatic check_map(input string tag);
        logic [11:0] p;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++) begin
                probe(c * 32 + 5, r * 32 + 7, p);
                chk($sformatf("%s_r%0d_c%0d", tag, r, c), {20'h0, p}, {28'h0, model[r * 20 + c]});
            end
    endtask

    task automatic set_model(input logic [3:0] t);
        for (int i = 0; i < 300; i++) model[i] = t;
    endtask

    task automatic run_sweep(input string tag, input int rst_at);
        int n;
        int ra;
        logic [11:0] acc;
        n = 0;
        ra = rst_at;
        acc = '0;
        h_cnt = 10'd10;
        v_cnt = 10'd10;
        active_in = 1'b1;
        wr_col = 5'd0;
        wr_row = 4'd0;
        wr_tile = 4'd9;
        fill_tile = 4'd3;
        while (busy && n < 400) begin
            wr_en = (n == 100);
            fill_en = (n == 120);
            rst = (n == ra);
            tick;
            acc |= pixel_out;
            if (rst) begin
                ra = -1;
                n = 0;
            end else n++;
            rst = 1'b0;
        end
        wr_en = 1'b0;
        fill_en = 1'b0;
        chk({tag, "_len"}, n, 300);
        chk({tag, "_blank"}, {20'h0, acc}, 0);
    endtask

    initial begin
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        active_in = 1'b1;
        rst = 1'b1;
        tick;
        chk("rst_pixel", {20'h0, pixel_out}, 0);
        chk("rst_hsync", {31'h0, hsync_out}, 1);
        chk("rst_vsync", {31'h0, vsync_out}, 1);
        chk("rst_rom_addr", {18'h0, rom_addr}, 0);
        chk("rst_busy", {31'h0, busy}, 1);
        rst = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        run_sweep("clear", -1);
        set_model(4'd1);
        check_map("init");

        h_cnt = 10'd37;
        v_cnt = 10'd7;
        tick;
        chk("rom_addr", {18'h0, rom_addr}, {18'h0, 4'd1, 5'd7, 5'd5});

        wr_en = 1'b1; wr_col = 5'd3; wr_row = 4'd2; wr_tile = 4'd7;
        tick;
        wr_en = 1'b0;
        model[2 * 20 + 3] = 4'd7;
        probe(96, 64, px);   chk("wr_tl", {20'h0, px}, 32'h7);
        probe(127, 95, px);  chk("wr_br", {20'h0, px}, 32'h7);
        probe(128, 64, px);  chk("wr_right", {20'h0, px}, 32'h1);
        probe(95, 95, px);   chk("wr_left", {20'h0, px}, 32'h1);
        probe(96, 96, px);   chk("wr_below", {20'h0, px}, 32'h1);

        wr_en = 1'b1; wr_col = 5'd20; wr_row = 4'd0; wr_tile = 4'd9;
        tick;
        wr_en = 1'b1; wr_col = 5'd0; wr_row = 4'd15; wr_tile = 4'd9;
        tick;
        wr_en = 1'b0;
        probe(5, 39, px);    chk("oob_col_ignored", {20'h0, px}, 32'h1);
        probe(5, 7, px);     chk("oob_row_ignored", {20'h0, px}, 32'h1);

        probe(640, 10, px);  chk("off_map_h", {20'h0, px}, 0);
        probe(10, 480, px);  chk("off_map_v", {20'h0, px}, 0);
        h_cnt = 10'd100; v_cnt = 10'd70; active_in = 1'b0;
        repeat (3) tick;
        chk("inactive", {20'h0, pixel_out}, 0);

        h_cnt = 10'd96; v_cnt = 10'd64; active_in = 1'b1;
        wr_en = 1'b1; wr_col = 5'd3; wr_row = 4'd2; wr_tile = 4'd2;
        tick;
        wr_en = 1'b0;
        tick;
        tick;
        chk("rf_old", {20'h0, pixel_out}, 32'h7);
        tick;
        chk("rf_new", {20'h0, pixel_out}, 32'h2);
        model[2 * 20 + 3] = 4'd2;

        hsync_in = 1'b0; vsync_in = 1'b0;
        tick;
        chk("hs_d1", {31'h0, hsync_out}, 1);
        tick;
        hsync_in = 1'b1; vsync_in = 1'b1;
        chk("hs_d2", {31'h0, hsync_out}, 1);
        tick;
        chk("hs_d3", {31'h0, hsync_out}, 0);
        chk("vs_d3", {31'h0, vsync_out}, 0);
        tick;
        chk("hs_d4", {31'h0, hsync_out}, 0);
        chk("vs_d4", {31'h0, vsync_out}, 0);
        tick;
        chk("hs_d5", {31'h0, hsync_out}, 1);
        chk("vs_d5", {31'h0, vsync_out}, 1);
        check_map("pre_fill");

        fill_en = 1'b1; fill_tile = 4'd5;
        wr_en = 1'b1; wr_col = 5'd1; wr_row = 4'd1; wr_tile = 4'd9;
        tick;
        fill_en = 1'b0; wr_en = 1'b0;
        chk("fill_busy", {31'h0, busy}, 1);
        run_sweep("fill", -1);
        set_model(4'd5);
        check_map("fill");

        fill_en = 1'b1; fill_tile = 4'd6;
        tick;
        fill_en = 1'b0;
        run_sweep("abort", 150);
        set_model(4'd1);
        check_map("abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
